// File: rtl/store_addr_buf.sv
// Four-entry FIFO store buffer with youngest-match load forwarding.
// Entries drain in order to the D-cache port; loads search all pending stores combinationally.

module cmp32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        eq
);
   assign eq = (a == b);
endmodule

module store_addr_buf #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_aL,
   input  logic                     enq_valid,
   input  logic [31:0]              enq_addr,
   input  logic [31:0]              enq_data,
   output logic                     enq_ready,
   output logic                     deq_valid,
   output logic [31:0]              deq_addr,
   output logic [31:0]              deq_data,
   input  logic                     deq_ready,
   input  logic [31:0]              ld_addr,
   output logic                     ld_hit,
   output logic [31:0]              ld_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [31:0]      addr_mem [DEPTH];
   logic [31:0]      data_mem [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [PW-1:0]    head_reg;
   logic [PW-1:0]    tail_reg;
   logic [CW-1:0]    count_reg;
   logic [CW-1:0]    count_next;
   logic             full_reg;
   logic             enq_fire;
   logic             deq_fire;
   logic [DEPTH-1:0] addr_eq;
   logic [DEPTH-1:0] match;
   logic [PW-1:0]    age_idx;

   // enq_ready comes only from a register so deq_ready never reaches it combinationally
   assign enq_ready = !full_reg;
   assign deq_valid = (count_reg != '0);
   assign enq_fire  = enq_valid && !full_reg;
   assign deq_fire  = deq_valid && deq_ready;
   assign deq_addr  = addr_mem[head_reg];
   assign deq_data  = data_mem[head_reg];
   assign count     = count_reg;

   always_comb begin
      count_next = count_reg;
      if (enq_fire && !deq_fire) begin
         count_next = count_reg + CW'(1);
      end else if (deq_fire && !enq_fire) begin
         count_next = count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
         valid_reg <= '0;
      end else begin
         if (deq_fire) begin
            valid_reg[head_reg] <= 1'b0;
            head_reg            <= head_reg + PW'(1);
         end
         if (enq_fire) begin
            valid_reg[tail_reg] <= 1'b1;
            tail_reg            <= tail_reg + PW'(1);
         end
         count_reg <= count_next;
         full_reg  <= (count_next == CW'(DEPTH));
      end
   end

   always_ff @(posedge clk) begin
      if (enq_fire) begin
         addr_mem[tail_reg] <= enq_addr;
         data_mem[tail_reg] <= enq_data;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
         cmp32 u_cmp (
            .a  (addr_mem[gi]),
            .b  (ld_addr),
            .eq (addr_eq[gi])
         );
         assign match[gi] = valid_reg[gi] & addr_eq[gi];
      end
   endgenerate

   // Walk entries oldest-to-youngest from head; a later match overrides, so the youngest wins
   always_comb begin
      ld_hit  = 1'b0;
      ld_data = '0;
      age_idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         age_idx = head_reg + PW'(k);
         if (match[age_idx]) begin
            ld_hit  = 1'b1;
            ld_data = data_mem[age_idx];
         end
      end
   end
endmodule

// File: tb/tb_store_addr_buf.sv
// Randomized and directed bench for store_addr_buf against a queue-based reference model.
// Dequeued entries are checked by a monitor popping from a scoreboard queue.

module tb_store_addr_buf;
   localparam int DEPTH = 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst_aL = 1'b0;
   logic        enq_valid = 1'b0;
   logic [31:0] enq_addr = '0;
   logic [31:0] enq_data = '0;
   logic        enq_ready;
   logic        deq_valid;
   logic [31:0] deq_addr;
   logic [31:0] deq_data;
   logic        deq_ready = 1'b0;
   logic [31:0] ld_addr = '0;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;

   entry_t mq[$];     // reference contents, oldest first
   entry_t exp_q[$];  // scoreboard of expected dequeues

   store_addr_buf #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_aL    (rst_aL),
      .enq_valid (enq_valid),
      .enq_addr  (enq_addr),
      .enq_data  (enq_data),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_addr  (deq_addr),
      .deq_data  (deq_data),
      .deq_ready (deq_ready),
      .ld_addr   (ld_addr),
      .ld_hit    (ld_hit),
      .ld_data   (ld_data),
      .count     (count)
   );

   always #10 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_ld(input logic [31:0] a, output bit hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      for (int i = mq.size() - 1; i >= 0; i--) begin
         if (mq[i].addr == a) begin
            hit = 1'b1;
            d   = mq[i].data;
            break;
         end
      end
   endfunction

   // Monitor: a dequeue presented this cycle must match the oldest expected store
   always @(negedge clk) begin
      if (rst_aL && deq_valid && deq_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL deq_unexpected: got addr 0x%08h expected no dequeue", deq_addr);
         end else begin
            entry_t e;
            e = exp_q.pop_front();
            chk("deq_addr", deq_addr, e.addr);
            chk("deq_data", deq_data, e.data);
            $display("deq addr=0x%08h data=0x%08h", deq_addr, deq_data);
         end
      end
   end

   // One clock of stimulus; called at posedge+1, returns at the next posedge+1
   task automatic step(input bit ev, input logic [31:0] ea, input logic [31:0] ed,
                       input bit dr, input logic [31:0] la);
      bit          h;
      logic [31:0] d;
      int          sz;
      entry_t      e;
      enq_valid = ev;
      enq_addr  = ea;
      enq_data  = ed;
      deq_ready = dr;
      ld_addr   = la;
      #1;
      model_ld(la, h, d);
      chk("count", 32'(count), 32'(mq.size()));
      chk("enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'(mq.size() != 0));
      chk("ld_hit", 32'(ld_hit), 32'(h));
      chk("ld_data", ld_data, d);
      @(posedge clk);
      sz = mq.size();
      if (dr && sz > 0) void'(mq.pop_front());
      if (ev && sz < DEPTH) begin
         e.addr = ea;
         e.data = ed;
         mq.push_back(e);
         exp_q.push_back(e);
         $display("enq addr=0x%08h data=0x%08h", ea, ed);
      end
      #1;
   endtask

   // Idle lookup against explicitly stated expectations; consumes no clock edge
   task automatic probe(input logic [31:0] la, input bit eh, input logic [31:0] ed, input int ec);
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      ld_addr   = la;
      #1;
      chk("probe_hit", 32'(ld_hit), 32'(eh));
      chk("probe_data", ld_data, ed);
      chk("probe_count", 32'(count), 32'(ec));
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, '0);
   endtask

   initial begin
      #3;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_deq_valid", 32'(deq_valid), 32'd0);
      chk("rst_enq_ready", 32'(enq_ready), 32'd1);
      chk("rst_ld_hit", 32'(ld_hit), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      #20 rst_aL = 1'b1;
      @(posedge clk);
      #1;

      // basic enqueue and lookup
      step(1'b1, 32'h100, 32'hAAAA0001, 1'b0, '0);
      step(1'b1, 32'h104, 32'hAAAA0002, 1'b0, '0);
      probe(32'h104, 1'b1, 32'hAAAA0002, 2);
      chk("head_addr", deq_addr, 32'h100);
      probe(32'h108, 1'b0, 32'h0, 2);
      drain(2);

      // youngest match wins
      step(1'b1, 32'h200, 32'h11, 1'b0, '0);
      step(1'b1, 32'h300, 32'h22, 1'b0, '0);
      step(1'b1, 32'h200, 32'h33, 1'b0, '0);
      probe(32'h200, 1'b1, 32'h33, 3);

      // asynchronous reset between edges with 3 entries held
      probe(32'h300, 1'b1, 32'h22, 3);
      #1 rst_aL = 1'b0;
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_deq_valid", 32'(deq_valid), 32'd0);
      chk("arst_ld_hit", 32'(ld_hit), 32'd0);
      chk("arst_ld_data", ld_data, 32'd0);
      chk("arst_enq_ready", 32'(enq_ready), 32'd1);
      mq.delete();
      exp_q.delete();
      #1 rst_aL = 1'b1;
      @(posedge clk);
      #1;

      // wrap: move head/tail to 3, then straddle the wrap with two same-address stores
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 32'h80 + 32'(i), 32'h70 + 32'(i), 1'b0, '0);
         step(1'b0, '0, '0, 1'b1, '0);
      end
      step(1'b1, 32'h40, 32'h1, 1'b0, '0);
      step(1'b1, 32'h40, 32'h2, 1'b0, '0);
      probe(32'h40, 1'b1, 32'h2, 2);
      drain(2);

      // full: refused enqueue while dequeue fires, accepted next cycle
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h700 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0, '0);
      probe(32'h70C, 1'b1, 32'hB3, 4);
      chk("full_enq_ready", 32'(enq_ready), 32'd0);
      step(1'b1, 32'h7F0, 32'h55, 1'b1, 32'h7F0);
      probe(32'h7F0, 1'b0, 32'h0, 3);
      step(1'b1, 32'h7F0, 32'h55, 1'b0, 32'h7F0);
      probe(32'h7F0, 1'b1, 32'h55, 4);
      drain(4);

      // dequeued head visible this cycle only; enqueue invisible until next cycle
      step(1'b1, 32'h500, 32'h9, 1'b0, '0);
      probe(32'h500, 1'b1, 32'h9, 1);
      step(1'b0, '0, '0, 1'b1, 32'h500);
      probe(32'h500, 1'b0, 32'h0, 0);
      step(1'b1, 32'h600, 32'h6, 1'b0, 32'h600);
      probe(32'h600, 1'b1, 32'h6, 1);
      drain(1);

      // randomized traffic over a small address pool so hits are frequent
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 99) < 60,
              32'h1000 + 32'($urandom_range(0, 7)) * 4,
              $urandom,
              $urandom_range(0, 99) < 50,
              32'h1000 + 32'($urandom_range(0, 8)) * 4);
      end
      drain(DEPTH + 1);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
